// File: rtl/signal_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// signal_conditioner_pkg: register map, field positions and reset values. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package signal_conditioner_pkg;

  localparam logic [31:0] SC_BASE_ADDR_DEFAULT = 32'h0000_0300;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_DIV      = 2'd1,
    REG_EDGE_CNT = 2'd2,
    REG_CLEAR    = 2'd3
  } reg_off_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FILT_LSB = 4;
  localparam int FILT_W        = 4;
  localparam int DIV_W         = 16;

  localparam logic [DIV_W-1:0] DIV_RESET = 16'd1;

  // A divider of zero behaves as a divider of one.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? 16'd1 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sig_glitch_filter.sv
// ----------------------------------------------------------------------------
// sig_glitch_filter: 2-flop synchroniser plus run-length glitch filter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sig_glitch_filter
  import signal_conditioner_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              raw,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level
);

  logic              sync1;
  logic              sync2;
  logic [FILT_W-1:0] run_cnt;

  // level follows sync2 only after filt_len+1 consecutive disagreeing samples;
  // >= keeps the filter sane if filt_len is lowered mid-run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt >= filt_len) begin
        level   <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/signal_conditioner.sv
// ----------------------------------------------------------------------------
// signal_conditioner: Wishbone-controlled edge counter and prescaler. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module signal_conditioner
  import signal_conditioner_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SC_BASE_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        lock_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  input  logic        tagn_i,
  input  logic        tagn_o,
  input  logic        signal_raw,
  output logic        signal_out,
  output logic        edge_pulse_o
);

  logic              ctrl_en;
  logic [FILT_W-1:0] filt_len;
  logic [DIV_W-1:0]  div;
  logic [31:0]       edge_cnt;
  logic [31:0]       edge_cnt_nxt;
  logic [DIV_W-1:0]  presc_cnt;
  logic [DIV_W-1:0]  presc_nxt;
  logic              out_q;
  logic              out_nxt;
  logic              level;
  logic              level_q;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic [31:0]       rdata;
  reg_off_e          off;
  logic              hit;
  logic              access;
  logic              wr_ctrl;
  logic              wr_div;
  logic              wr_clear;

  sig_glitch_filter u_filter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raw      (signal_raw),
    .filt_len (filt_len),
    .level    (level)
  );

  assign off      = reg_off_e'(addr_i[3:2]);
  assign hit      = cyc_i & stb_i & (addr_i[31:4] == BASE_ADDR[31:4]);
  // One access per ack: a held strobe gets a fresh access only after the ack cycle.
  assign access   = hit & ~ack_q;
  assign wr_ctrl  = access & we_i & (off == REG_CTRL);
  assign wr_div   = access & we_i & (off == REG_DIV);
  assign wr_clear = access & we_i & (off == REG_CLEAR);

  assign edge_pulse_o = level & ~level_q & ctrl_en;
  assign signal_out   = out_q & ctrl_en;
  assign ack_o        = ack_q;
  assign dat_o        = dat_q;
  assign err_o        = 1'b0;
  assign rty_o        = 1'b0;

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    presc_nxt    = presc_cnt;
    out_nxt      = out_q;
    if (edge_pulse_o) begin
      edge_cnt_nxt = edge_cnt + 32'd1;
      if (presc_cnt == eff_div(div) - 16'd1) begin
        presc_nxt = '0;
        out_nxt   = ~out_q;
      end else begin
        presc_nxt = presc_cnt + 16'd1;
      end
    end
    if (wr_div) begin
      presc_nxt = '0;
      out_nxt   = out_q;
    end
    // Clear beats a coincident edge.
    if (wr_clear) begin
      edge_cnt_nxt = '0;
      presc_nxt    = '0;
      out_nxt      = out_q;
    end
    if (!ctrl_en) begin
      out_nxt = 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]               = ctrl_en;
        rdata[CTRL_FILT_LSB +: FILT_W]   = filt_len;
      end
      REG_DIV:      rdata[DIV_W-1:0] = div;
      REG_EDGE_CNT: rdata            = edge_cnt;
      default:      rdata            = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en   <= 1'b0;
      filt_len  <= '0;
      div       <= DIV_RESET;
      edge_cnt  <= '0;
      presc_cnt <= '0;
      out_q     <= 1'b0;
      level_q   <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      ack_q     <= access;
      dat_q     <= (access & ~we_i) ? rdata : 32'd0;
      level_q   <= level;
      edge_cnt  <= edge_cnt_nxt;
      presc_cnt <= presc_nxt;
      out_q     <= out_nxt;
      if (wr_ctrl && sel_i[0]) begin
        ctrl_en  <= dat_i[CTRL_EN_BIT];
        filt_len <= dat_i[CTRL_FILT_LSB +: FILT_W];
      end
      if (wr_div && sel_i[0]) begin
        div[7:0] <= dat_i[7:0];
      end
      if (wr_div && sel_i[1]) begin
        div[15:8] <= dat_i[15:8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, lock_i, tagn_i, tagn_o, addr_i[1:0], dat_i[31:16],
                       dat_i[3:1], sel_i[3:2]};

endmodule

`default_nettype wire

// File: tb/tb_signal_conditioner.sv
// ----------------------------------------------------------------------------
// tb_signal_conditioner: directed, table-driven bench for signal_conditioner. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_signal_conditioner;

  localparam logic [31:0] BASE  = 32'h0000_0300;
  localparam logic [31:0] A_CTL = BASE + 32'h0;
  localparam logic [31:0] A_DIV = BASE + 32'h4;
  localparam logic [31:0] A_CNT = BASE + 32'h8;
  localparam logic [31:0] A_CLR = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        lock = 1'b0;
  logic        ack;
  logic        err;
  logic        rty;
  logic        tagn_in = 1'b0;
  logic        tagn_out_in = 1'b0;
  logic        signal_raw = 1'b0;
  logic        signal_out;
  logic        edge_pulse;

  always #5 clk = ~clk;

  signal_conditioner #(.BASE_ADDR(BASE)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .addr_i       (addr),
    .dat_i        (wdat),
    .dat_o        (rdat),
    .we_i         (we),
    .sel_i        (sel),
    .cyc_i        (cyc),
    .stb_i        (stb),
    .lock_i       (lock),
    .ack_o        (ack),
    .err_o        (err),
    .rty_o        (rty),
    .tagn_i       (tagn_in),
    .tagn_o       (tagn_out_in),
    .signal_raw   (signal_raw),
    .signal_out   (signal_out),
    .edge_pulse_o (edge_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction; reports ack, its latency, read data, dat_o hygiene.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic acked, output int lat,
                         output logic [31:0] rd, output logic clean);
    int waited;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdat = d;
    acked = 1'b0; rd = '0; clean = 1'b1; waited = 0; lat = 0;
    while (!acked && waited < 4) begin
      tick();
      waited++;
      if (ack === 1'b1) begin
        acked = 1'b1; rd = rdat; lat = waited;
      end else if (rdat !== 32'd0) begin
        clean = 1'b0;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    if (ack !== 1'b0 || rdat !== 32'd0) clean = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic acked, clean; int lat; logic [31:0] rd;
    wb_xfer(1'b1, a, 4'hF, d, acked, lat, rd, clean);
    check("wr_ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic acked, clean; int lat;
    wb_xfer(1'b0, a, 4'hF, 32'd0, acked, lat, d, clean);
    check("rd_ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(name, d, exp);
  endtask

  int   w_pulses;
  int   w_toggles;
  int   tog_edge[$];
  int   rise_cyc[$];
  logic out_rec[512];
  logic ref_rec[512];

  task automatic run_wave(input int n_edges, input int half);
    int total; logic prev;
    total = n_edges * 2 * half + 10;
    w_pulses = 0; w_toggles = 0;
    tog_edge.delete(); rise_cyc.delete();
    prev = signal_out;
    for (int c = 0; c < total; c++) begin
      signal_raw = (c < n_edges * 2 * half) && ((c % (2 * half)) < half);
      tick();
      if (edge_pulse === 1'b1) w_pulses++;
      if (signal_out !== prev) begin
        w_toggles++;
        tog_edge.push_back(w_pulses);
        if (signal_out === 1'b1) rise_cyc.push_back(c);
      end
      prev = signal_out;
      if (c < 512) out_rec[c] = signal_out;
    end
    signal_raw = 1'b0;
  endtask

  task automatic prep(input logic [31:0] ctrl, input logic [31:0] divv);
    signal_raw = 1'b0;
    repeat (20) tick();
    wb_write(A_CTL, 32'd0);
    wb_write(A_DIV, divv);
    wb_write(A_CLR, 32'd0);
    wb_write(A_CTL, ctrl);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acked, clean;
    int lat, cnt, at;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, A_CTL, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b0, A_DIV, 4'hF, 32'h0,         1'b1, 32'h0000_0001};
    vecs[2]  = '{1'b0, A_CNT, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, A_CLR, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, A_CTL, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, A_CTL, 4'hF, 32'h0,         1'b1, 32'h0000_00F1};
    vecs[6]  = '{1'b1, A_CTL, 4'h2, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b0, A_CTL, 4'hF, 32'h0,         1'b1, 32'h0000_00F1};
    vecs[8]  = '{1'b1, A_CTL, 4'h1, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b1, A_DIV, 4'h3, 32'hABCD_1234, 1'b1, 32'h0};
    vecs[10] = '{1'b1, A_DIV, 4'h2, 32'h0000_5600, 1'b1, 32'h0};
    vecs[11] = '{1'b0, A_DIV, 4'hF, 32'h0,         1'b1, 32'h0000_5634};
    vecs[12] = '{1'b1, A_CNT, 4'hF, 32'h0000_0055, 1'b1, 32'h0};
    vecs[13] = '{1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 32'h0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset ack_o", {31'd0, ack}, 32'd0);
    check("reset dat_o", rdat, 32'd0);
    check("reset signal_out", {31'd0, signal_out}, 32'd0);
    check("reset edge_pulse", {31'd0, edge_pulse}, 32'd0);
    check("err_rty", {30'd0, err, rty}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      wb_xfer(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, acked, lat, rd, clean);
      check($sformatf("vec%0d ack", i), {31'd0, acked}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d data", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d dat_o idle", i), {31'd0, clean}, 32'd1);
      if (vecs[i].exp_ack) check($sformatf("vec%0d latency", i), lat, 1);
    end
    read_check("cnt after ro write", A_CNT, 32'd0);

    // Scenario 1: DIV=1, 10-clock square wave
    prep(32'h01, 32'd1);
    run_wave(5, 5);
    check("s1 pulses", w_pulses, 5);
    check("s1 toggles", w_toggles, 5);
    check("s1 rises", rise_cyc.size(), 3);
    if (rise_cyc.size() >= 3) begin
      check("s1 period a", rise_cyc[1] - rise_cyc[0], 20);
      check("s1 period b", rise_cyc[2] - rise_cyc[1], 20);
    end
    read_check("s1 edge_cnt", A_CNT, 32'd5);

    // Scenario 2: filt_len=3, glitch rejection and pulse latency
    prep(32'h31, 32'd1);
    cnt = 0; at = 0;
    signal_raw = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (edge_pulse === 1'b1) cnt++;
      if (i == 3) signal_raw = 1'b0;
    end
    check("s2 glitch pulses", cnt, 0);
    read_check("s2 glitch cnt", A_CNT, 32'd0);
    cnt = 0;
    signal_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (edge_pulse === 1'b1) begin cnt++; at = i; end
      if (i == 4) signal_raw = 1'b0;
    end
    check("s2 pulse count", cnt, 1);
    check("s2 pulse latency", at, 6);
    read_check("s2 edge_cnt", A_CNT, 32'd1);

    // Scenario 3: DIV=0 vs DIV=1, DIV=4, DIV write zeroes prescaler
    prep(32'h01, 32'd1);
    run_wave(4, 5);
    for (int c = 0; c < 512; c++) ref_rec[c] = out_rec[c];
    prep(32'h01, 32'd0);
    run_wave(4, 5);
    cnt = 0;
    for (int c = 0; c < 50; c++) if (out_rec[c] !== ref_rec[c]) cnt++;
    check("s3 div0 vs div1 diffs", cnt, 0);
    check("s3 div0 toggles", w_toggles, 4);
    prep(32'h01, 32'd4);
    run_wave(8, 5);
    check("s3 div4 toggles", w_toggles, 2);
    if (tog_edge.size() >= 2) begin
      check("s3 div4 first toggle edge", tog_edge[0], 4);
      check("s3 div4 second toggle edge", tog_edge[1], 8);
    end
    prep(32'h01, 32'd2);
    run_wave(1, 5);
    check("s3 div2 edge1 toggles", w_toggles, 0);
    wb_write(A_DIV, 32'd2);
    check("s3 div write keeps out", {31'd0, signal_out}, 32'd0);
    run_wave(1, 5);
    check("s3 after div write no toggle", w_toggles, 0);
    run_wave(1, 5);
    check("s3 second edge toggles", w_toggles, 1);

    // Scenario 4: wrap and clear/edge collision
    prep(32'h01, 32'd1);
    force dut.edge_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.edge_cnt;
    read_check("s4 preload", A_CNT, 32'hFFFF_FFFF);
    run_wave(1, 5);
    read_check("s4 wrap", A_CNT, 32'd0);
    run_wave(1, 5);
    read_check("s4 after wrap", A_CNT, 32'd1);
    signal_raw = 1'b1;
    repeat (3) tick();
    check("s4 pulse present", {31'd0, edge_pulse}, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = A_CLR; sel = 4'hF; wdat = 32'd0;
    tick();
    check("s4 clear ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    signal_raw = 1'b0;
    repeat (8) tick();
    read_check("s4 clear wins", A_CNT, 32'd0);

    // Scenario 6: reset mid-read
    prep(32'h01, 32'd1);
    run_wave(1, 5);
    wb_write(A_CTL, 32'h51);
    wb_write(A_DIV, 32'd7);
    check("s6 out before reset", {31'd0, signal_out}, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_CNT; sel = 4'hF;
    rst = 1'b1;
    tick();
    check("s6 no ack in reset", {31'd0, ack}, 32'd0);
    check("s6 dat_o in reset", rdat, 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();
    check("s6 no ack after reset", {31'd0, ack}, 32'd0);
    check("s6 signal_out", {31'd0, signal_out}, 32'd0);
    read_check("s6 ctrl", A_CTL, 32'd0);
    read_check("s6 div", A_DIV, 32'd1);
    read_check("s6 edge_cnt", A_CNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
